// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 8-bit, 4-register core: stall/bubble/flush
// decisions, in-flight destination scoreboard and IN-port handshake.
module pipe_hazard_ctrl #(
    parameter bit FWD_EN    = 1'b1,
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [1:0]       id_src1,
    input  logic [1:0]       id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [1:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r,
    input  logic             id_in_port,
    input  logic             in_valid,
    input  logic             br_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush_ifid,
    output logic             in_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       v;
        logic       wb;
        logic [1:0] dest;
        logic       ld;
    } slot_t;

    typedef enum logic {IDLE, WAIT_IN} state_e;

    slot_t            exe_q, mem_q, wb_q, exe_d;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_hazard, in_wait, issue;

    function automatic logic raw(input slot_t s, input logic u1,
                                 input logic [1:0] s1, input logic u2,
                                 input logic [1:0] s2);
        return s.v & s.wb & ((u1 & (s.dest == s1)) | (u2 & (s.dest == s2)));
    endfunction

    logic hit_exe, hit_mem, hit_wb;

    assign hit_exe = raw(exe_q, id_use1, id_src1, id_use2, id_src2);
    assign hit_mem = raw(mem_q, id_use1, id_src1, id_use2, id_src2);
    assign hit_wb  = raw(wb_q, id_use1, id_src1, id_use2, id_src2);

    always_comb begin
        data_hazard = 1'b0;
        if (id_valid) begin
            if (FWD_EN)
                data_hazard = hit_exe & exe_q.ld;
            else
                data_hazard = hit_exe | hit_mem | (!WB_BYPASS & hit_wb);
        end
    end

    assign in_wait = id_valid & id_in_port & !in_valid;
    assign issue   = id_valid & !br_taken & !data_hazard & !in_wait;

    // Outputs are forced low while reset is held so a stall drops at once.
    always_comb begin
        stall      = 1'b0;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        in_ack     = 1'b0;
        if (!rst) begin
            if (br_taken) begin
                flush_ifid = 1'b1;
                bubble     = 1'b1;
            end else if (!id_valid) begin
                bubble = 1'b1;
            end else if (data_hazard | in_wait) begin
                stall  = 1'b1;
                bubble = 1'b1;
            end else begin
                in_ack = id_in_port & in_valid;
            end
        end
    end

    always_comb begin
        exe_d = '0;
        if (issue)
            exe_d = '{v: 1'b1, wb: id_wb_en, dest: id_dest, ld: id_mem_r};
    end

    assign cnt_d = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= exe_q;
            wb_q  <= mem_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE:
                    if (id_valid & id_in_port & !in_valid
                        & !br_taken & !data_hazard)
                        state_q <= WAIT_IN;
                WAIT_IN:
                    if (in_valid | br_taken)
                        state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl in three
// forwarding/bypass configurations against an issue-history model.
module tb_pipe_hazard_ctrl;

    logic       clk, rst;
    logic       id_valid, id_use1, id_use2, id_wb_en, id_mem_r;
    logic [1:0] id_src1, id_src2, id_dest;
    logic       id_in_port, in_valid, br_taken;

    logic        s_w [3];
    logic        b_w [3];
    logic        f_w [3];
    logic        a_w [3];
    logic [15:0] c_w [3];

    int n_cmp = 0;
    int n_bad = 0;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .WB_BYPASS(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
        .id_in_port(id_in_port), .in_valid(in_valid),
        .br_taken(br_taken), .stall(s_w[0]), .bubble(b_w[0]),
        .flush_ifid(f_w[0]), .in_ack(a_w[0]), .stall_cnt(c_w[0]));

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b1), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
        .id_in_port(id_in_port), .in_valid(in_valid),
        .br_taken(br_taken), .stall(s_w[1]), .bubble(b_w[1]),
        .flush_ifid(f_w[1]), .in_ack(a_w[1]), .stall_cnt(c_w[1]));

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .WB_BYPASS(1'b0), .CNT_W(16)) u_nobyp (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
        .id_in_port(id_in_port), .in_valid(in_valid),
        .br_taken(br_taken), .stall(s_w[2]), .bubble(b_w[2]),
        .flush_ifid(f_w[2]), .in_ack(a_w[2]), .stall_cnt(c_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: list of issued instructions stamped with their issue cycle.
    typedef struct {
        int       k;
        int       cyc;
        bit       wb;
        bit [1:0] dest;
        bit       ld;
    } rec_t;

    rec_t hist[$];
    int   cyc = 0;
    int   mcnt [3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_haz(int k);
        bit h = 0;
        int age;
        bit m;
        foreach (hist[i]) begin
            age = cyc - hist[i].cyc;
            m = hist[i].k == k && hist[i].wb &&
                ((id_use1 && hist[i].dest == id_src1) ||
                 (id_use2 && hist[i].dest == id_src2));
            if (m) begin
                if (k == 0)
                    h |= (age == 1 && hist[i].ld);
                else if (age >= 1 && age <= (k == 1 ? 2 : 3))
                    h = 1;
            end
        end
        return h;
    endfunction

    task automatic model_eval(input int k, output bit st, output bit bb,
                              output bit fl, output bit ak, output bit iss);
        st = 0; bb = 0; fl = 0; ak = 0; iss = 0;
        if (rst) return;
        if (br_taken) begin
            fl = 1; bb = 1;
        end else if (!id_valid) begin
            bb = 1;
        end else if (model_haz(k) || (id_in_port && !in_valid)) begin
            st = 1; bb = 1;
        end else begin
            iss = 1;
            ak = id_in_port && in_valid;
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 3; k++) mcnt[k] = 0;
    endtask

    task automatic check_all();
        bit st, bb, fl, ak, iss;
        for (int k = 0; k < 3; k++) begin
            model_eval(k, st, bb, fl, ak, iss);
            chk($sformatf("stall%0d", k), 32'(s_w[k]), 32'(st));
            chk($sformatf("bubble%0d", k), 32'(b_w[k]), 32'(bb));
            chk($sformatf("flush%0d", k), 32'(f_w[k]), 32'(fl));
            chk($sformatf("in_ack%0d", k), 32'(a_w[k]), 32'(ak));
            chk($sformatf("cnt%0d", k), 32'(c_w[k]), 32'(mcnt[k]));
        end
    endtask

    task automatic commit();
        bit st, bb, fl, ak, iss;
        rec_t r;
        for (int k = 0; k < 3; k++) begin
            model_eval(k, st, bb, fl, ak, iss);
            if (st && mcnt[k] < 65535) mcnt[k]++;
            if (iss) begin
                r.k = k; r.cyc = cyc; r.wb = id_wb_en;
                r.dest = id_dest; r.ld = id_mem_r;
                hist.push_back(r);
            end
        end
        cyc++;
        while (hist.size() > 0 && cyc - hist[0].cyc > 3)
            void'(hist.pop_front());
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit [1:0] s1, input bit u1,
                         input bit [1:0] s2, input bit u2,
                         input bit [1:0] d, input bit wb, input bit ld,
                         input bit inp, input bit inv, input bit br);
        id_valid = v; id_src1 = s1; id_use1 = u1;
        id_src2 = s2; id_use2 = u2; id_dest = d;
        id_wb_en = wb; id_mem_r = ld;
        id_in_port = inp; in_valid = inv; br_taken = br;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load R1 then a consumer of R1 held in ID for four cycles.
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("loaduse_fwd", 32'(c_w[0]), 32'd1);
        chk("raw_nofwd", 32'(c_w[1]), 32'd2);
        chk("raw_nobyp", 32'(c_w[2]), 32'd3);

        // Taken branch while ID has a hazard on R3.
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // IN instruction waits four cycles for input data.
        do_reset();
        drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0);
        repeat (4) tick();
        chk("in_wait_cnt", 32'(c_w[0]), 32'd4);
        drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset asserted during a load-use stall.
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        tick();
        drive(1, 1, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all();
        rst = 1'b1;
        #1;
        chk("rst_stall", 32'(s_w[0]), 32'd0);
        chk("rst_cnt", 32'(c_w[0]), 32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        #1;
        check_all();
        commit();
        @(posedge clk);
        #1;

        // Random traffic.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 8,
                  2'($urandom), $urandom_range(0, 3) != 0,
                  2'($urandom), $urandom_range(0, 1) == 1,
                  2'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 2,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 11) == 0);
            tick();
        end

        // Counter saturation over 2^16+3 stall cycles.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        repeat (65539) tick();
        chk("sat0", 32'(c_w[0]), 32'hFFFF);
        chk("sat2", 32'(c_w[2]), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
